// File: rtl/gb_joypad.sv
// gb_joypad: DualShock2 key/stick outputs -> Game Boy P1/JOYP (FF00) register
// plus joypad interrupt. Keys are synchronised, debounced and SOCD-cleaned;
// the left stick folds into the D-pad with hysteresis.
// Optional feature macro: GB_JOYPAD_TURBO_EN (square/triangle act as turbo A/B).

// Per-key 2-flop synchroniser followed by a tick-based debouncer.
module gb_joypad_deb #(
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic raw_i,
  output logic key_o
);
  logic       s1_q, s2_q, key_q;
  logic [3:0] cnt_q;

  // Bring the asynchronous key into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Accept a new level only after DEBOUNCE_CNT consecutive disagreeing ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= 1'b0;
      cnt_q <= 4'd0;
    end else if (tick_i) begin
      if (s2_q != key_q) begin
        if (cnt_q == 4'(DEBOUNCE_CNT - 1)) begin
          key_q <= s2_q;
          cnt_q <= 4'd0;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end else begin
        cnt_q <= 4'd0;
      end
    end
  end

  assign key_o = key_q;
endmodule

module gb_joypad #(
  parameter int         TICK_DIV     = 4096,
  parameter int         DEBOUNCE_CNT = 3,
  parameter logic [7:0] STICK_LO_ON  = 8'h40,
  parameter logic [7:0] STICK_LO_OFF = 8'h60,
  parameter logic [7:0] STICK_HI_ON  = 8'hC0,
  parameter logic [7:0] STICK_HI_OFF = 8'hA0,
  parameter int         TURBO_TICKS  = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_circle,
  input  logic       key_cross,
  input  logic       key_start,
  input  logic       key_select,
  input  logic       key_square,
  input  logic       key_triangle,
  input  logic       stick_en,
  input  logic [7:0] stick_lx,
  input  logic [7:0] stick_ly,
  input  logic       reg_wr,
  input  logic [7:0] reg_din,
  output logic [7:0] reg_dout,
  output logic       int_req
);
`ifdef GB_JOYPAD_TURBO_EN
  localparam int NK = 10;
`else
  localparam int NK = 8;
`endif
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // raw key order: up, down, left, right, circle(A), cross(B), start, select, square, triangle
  logic [9:0]    raw;
  logic [NK-1:0] db;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic [1:0]    sel_q;
  logic [3:0]    lines_q, prev_q, mat;
  logic          sen_s1_q, sen_s2_q;
  logic [7:0]    lx_s1_q, lx_s2_q, lx_s3_q, ly_s1_q, ly_s2_q, ly_s3_q, lx_h_q, ly_h_q;
  logic [7:0]    ax, ay;
  logic          stk_stable;
  logic          st_up_q, st_dn_q, st_lf_q, st_rt_q;
  logic          btn_a, btn_b, u, d, l, r;

  assign raw = {key_triangle, key_square, key_select, key_start, key_cross, key_circle,
                key_right, key_left, key_down, key_up};

  // Free-running sample tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
  end
  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  generate
    for (genvar g = 0; g < NK; g++) begin : g_deb
      gb_joypad_deb #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_deb (
        .clk(clk), .rst_n(rst_n), .tick_i(tick), .raw_i(raw[g]), .key_o(db[g])
      );
    end
  endgenerate

  // Synchronise stick_en and both stick axes; third stage detects a settled bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sen_s1_q <= 1'b0; sen_s2_q <= 1'b0;
      lx_s1_q <= '0; lx_s2_q <= '0; lx_s3_q <= '0;
      ly_s1_q <= '0; ly_s2_q <= '0; ly_s3_q <= '0;
    end else begin
      sen_s1_q <= stick_en; sen_s2_q <= sen_s1_q;
      lx_s1_q <= stick_lx; lx_s2_q <= lx_s1_q; lx_s3_q <= lx_s2_q;
      ly_s1_q <= stick_ly; ly_s2_q <= ly_s1_q; ly_s3_q <= ly_s2_q;
    end
  end

  // A multi-bit bus crossing is only trusted once it has held for two clocks
  assign stk_stable = (lx_s2_q == lx_s3_q) && (ly_s2_q == ly_s3_q);
  assign ax = stk_stable ? lx_s2_q : lx_h_q;
  assign ay = stk_stable ? ly_s2_q : ly_h_q;

  // Holding register: refreshed on tick when the bus is settled, stale otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lx_h_q <= '0;
      ly_h_q <= '0;
    end else if (tick && stk_stable) begin
      lx_h_q <= lx_s2_q;
      ly_h_q <= ly_s2_q;
    end
  end

  // Stick-to-D-pad fold with hysteresis; threshold-equal values hold state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {st_up_q, st_dn_q, st_lf_q, st_rt_q} <= 4'b0;
    end else if (!sen_s2_q) begin
      {st_up_q, st_dn_q, st_lf_q, st_rt_q} <= 4'b0;
    end else if (tick) begin
      if (ax < STICK_LO_ON) st_lf_q <= 1'b1; else if (ax > STICK_LO_OFF) st_lf_q <= 1'b0;
      if (ax > STICK_HI_ON) st_rt_q <= 1'b1; else if (ax < STICK_HI_OFF) st_rt_q <= 1'b0;
      if (ay < STICK_LO_ON) st_up_q <= 1'b1; else if (ay > STICK_LO_OFF) st_up_q <= 1'b0;
      if (ay > STICK_HI_ON) st_dn_q <= 1'b1; else if (ay < STICK_HI_OFF) st_dn_q <= 1'b0;
    end
  end

`ifdef GB_JOYPAD_TURBO_EN
  logic [7:0] turbo_cnt_q;
  logic       phase_q;
  logic       unused_bits;
  assign unused_bits = ^{reg_din[7:6], reg_din[3:0]};

  // Turbo phase: starts pressed, flips every TURBO_TICKS ticks while a turbo key is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turbo_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (!(db[8] | db[9])) begin
      turbo_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (tick) begin
      if (turbo_cnt_q == 8'(TURBO_TICKS - 1)) begin
        turbo_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        turbo_cnt_q <= turbo_cnt_q + 8'd1;
      end
    end
  end
  assign btn_a = db[4] | (db[8] & phase_q);
  assign btn_b = db[5] | (db[9] & phase_q);
`else
  logic unused_bits;
  assign unused_bits = ^{raw[9:8], reg_din[7:6], reg_din[3:0]};
  assign btn_a = db[4];
  assign btn_b = db[5];
`endif

  // Merge keys with stick, drop opposing directions, then build the active-low matrix
  always_comb begin
    u = db[0] | st_up_q;
    d = db[1] | st_dn_q;
    l = db[2] | st_lf_q;
    r = db[3] | st_rt_q;
    if (u && d) begin u = 1'b0; d = 1'b0; end
    if (l && r) begin l = 1'b0; r = 1'b0; end
    mat[0] = ~((~sel_q[0] & r) | (~sel_q[1] & btn_a));
    mat[1] = ~((~sel_q[0] & l) | (~sel_q[1] & btn_b));
    mat[2] = ~((~sel_q[0] & u) | (~sel_q[1] & db[7]));
    mat[3] = ~((~sel_q[0] & d) | (~sel_q[1] & db[6]));
  end

  // CPU-visible select bits and registered lines with one-clk history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= 2'b11;
      lines_q <= 4'hF;
      prev_q  <= 4'hF;
    end else begin
      if (reg_wr) sel_q <= reg_din[5:4];
      lines_q <= mat;
      prev_q  <= lines_q;
    end
  end

  assign reg_dout = {2'b11, sel_q, lines_q};
  assign int_req  = |(prev_q & ~lines_q);
endmodule

// File: tb/tb_gb_joypad.sv
// Self-checking bench for gb_joypad: directed scenarios plus randomized
// key/select and stick sequences checked against a key-level reference model.
module tb_gb_joypad;
  localparam int TD = 16;
  localparam int TT = 33;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       key_up = 0, key_down = 0, key_left = 0, key_right = 0;
  logic       key_circle = 0, key_cross = 0, key_start = 0, key_select = 0;
  logic       key_square = 0, key_triangle = 0, stick_en = 0, reg_wr = 0;
  logic [7:0] stick_lx = 8'h80, stick_ly = 8'h80, reg_din = 8'h00;
  logic [7:0] reg_dout;
  logic       int_req;

  int checks = 0, errors = 0, int_cnt = 0;

  gb_joypad #(.TICK_DIV(TD), .DEBOUNCE_CNT(3), .TURBO_TICKS(TT)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .key_circle(key_circle), .key_cross(key_cross), .key_start(key_start),
    .key_select(key_select), .key_square(key_square), .key_triangle(key_triangle),
    .stick_en(stick_en), .stick_lx(stick_lx), .stick_ly(stick_ly),
    .reg_wr(reg_wr), .reg_din(reg_din), .reg_dout(reg_dout), .int_req(int_req)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (int_req === 1'b1) int_cnt++;

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    clks(n * TD);
  endtask

  // k: 0 up,1 down,2 left,3 right,4 circle,5 cross,6 start,7 select,8 square,9 triangle
  task automatic set_keys(input logic [9:0] k);
    {key_triangle, key_square, key_select, key_start, key_cross, key_circle,
     key_right, key_left, key_down, key_up} = k;
  endtask

  task automatic wr_sel(input logic [7:0] din);
    reg_din = din; reg_wr = 1'b1;
    clks(1);
    reg_wr = 1'b0;
    clks(1);
  endtask

  task automatic do_reset();
    set_keys(10'b0); stick_en = 0; stick_lx = 8'h80; stick_ly = 8'h80; reg_wr = 0;
    rst_n = 1'b0; clks(2); rst_n = 1'b1; clks(2);
  endtask

  // Reference: FF00 value from select bits, settled keys and stick direction flags
  // stk = {right, left, down, up}
  function automatic logic [7:0] exp_dout(input logic [1:0] s, input logic [9:0] k,
                                          input logic [3:0] stk);
    logic u, d, l, r;
    logic [3:0] dir, btn, low;
    u = k[0] | stk[0]; d = k[1] | stk[1]; l = k[2] | stk[2]; r = k[3] | stk[3];
    if (u && d) begin u = 0; d = 0; end
    if (l && r) begin l = 0; r = 0; end
    dir = {d, u, l, r};
    btn = {k[6], k[7], k[5], k[4]};
    low = 4'hF;
    if (!s[0]) low = low & ~dir;
    if (!s[1]) low = low & ~btn;
    return {2'b11, s, low};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; clks(1);
    checks++; if (reg_dout !== 8'hFF) begin errors++; $display("FAIL reset_dout got %h want ff", reg_dout); end
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL reset_int got %b want 0", int_req); end
    do_reset();
    checks++; if (reg_dout !== 8'hFF) begin errors++; $display("FAIL post_reset_dout got %h want ff", reg_dout); end
  endtask

  task automatic test_sel_write();
    int c0;
    do_reset(); c0 = int_cnt;
    wr_sel(8'h10);
    checks++; if (reg_dout !== 8'hDF) begin errors++; $display("FAIL sel_write got %h want df", reg_dout); end
    ticks(4);
    checks++; if (int_cnt != c0) begin errors++; $display("FAIL sel_write_int got %0d want 0 pulses", int_cnt - c0); end
  endtask

  task automatic test_right();
    int c0;
    do_reset(); wr_sel(8'h20); c0 = int_cnt;
    key_right = 1; ticks(6);
    checks++; if (reg_dout !== 8'hEE) begin errors++; $display("FAIL right_press got %h want ee", reg_dout); end
    checks++; if (int_cnt - c0 != 1) begin errors++; $display("FAIL right_int got %0d want 1 pulse", int_cnt - c0); end
    c0 = int_cnt; key_right = 0; ticks(6);
    checks++; if (reg_dout !== 8'hEF) begin errors++; $display("FAIL right_release got %h want ef", reg_dout); end
    checks++; if (int_cnt != c0) begin errors++; $display("FAIL right_release_int got %0d want 0", int_cnt - c0); end
  endtask

  task automatic test_glitch();
    int c0;
    do_reset(); wr_sel(8'h10); c0 = int_cnt;
    key_circle = 1; clks(30); key_circle = 0; ticks(6);
    checks++; if (reg_dout !== 8'hDF) begin errors++; $display("FAIL glitch_dout got %h want df", reg_dout); end
    checks++; if (int_cnt != c0) begin errors++; $display("FAIL glitch_int got %0d want 0", int_cnt - c0); end
  endtask

  task automatic test_socd();
    int c0;
    do_reset(); wr_sel(8'h20);
    key_up = 1; key_down = 1; ticks(6);
    checks++; if (reg_dout[3:2] !== 2'b11) begin errors++; $display("FAIL socd_both got %b want 11", reg_dout[3:2]); end
    c0 = int_cnt; key_down = 0; ticks(6);
    checks++; if (reg_dout[3:2] !== 2'b10) begin errors++; $display("FAIL socd_release got %b want 10", reg_dout[3:2]); end
    checks++; if (int_cnt - c0 != 1) begin errors++; $display("FAIL socd_int got %0d want 1", int_cnt - c0); end
  endtask

  task automatic test_stick();
    logic [7:0] xs [0:12] = '{8'h80, 8'h30, 8'h50, 8'h70, 8'h40, 8'h3F, 8'h40, 8'h60, 8'h61,
                              8'hC0, 8'hC1, 8'hA0, 8'h9F};
    logic lf, rt, up, dn;
    logic [7:0] v, w, e;
    do_reset(); wr_sel(8'h20); stick_en = 1; ticks(3);
    lf = 0; rt = 0; up = 0; dn = 0;
    for (int i = 0; i < 33; i++) begin
      if (i < 13) begin v = xs[i]; w = 8'h80; end
      else begin v = 8'($urandom); w = 8'($urandom); end
      stick_lx = v; stick_ly = w; ticks(3);
      if (v < 8'h40) lf = 1; else if (v > 8'h60) lf = 0;
      if (v > 8'hC0) rt = 1; else if (v < 8'hA0) rt = 0;
      if (w < 8'h40) up = 1; else if (w > 8'h60) up = 0;
      if (w > 8'hC0) dn = 1; else if (w < 8'hA0) dn = 0;
      e = exp_dout(2'b10, 10'b0, {rt, lf, dn, up});
      checks++; if (reg_dout !== e) begin errors++; $display("FAIL stick[%0d] lx=%h ly=%h got %h want %h", i, v, w, reg_dout, e); end
    end
    stick_lx = 8'h30; ticks(3);
    stick_en = 0; clks(6);
    checks++; if (reg_dout !== 8'hEF) begin errors++; $display("FAIL stick_disable got %h want ef", reg_dout); end
  endtask

  task automatic test_random();
    logic [1:0] cs;
    logic [9:0] ck, nk;
    logic [7:0] din, bef, aft;
    int c0, want;
    do_reset(); cs = 2'b11; ck = '0;
    for (int i = 0; i < 25; i++) begin
      din = 8'($urandom);
      bef = exp_dout(cs, ck, 4'b0); aft = exp_dout(din[5:4], ck, 4'b0);
      want = (|(bef[3:0] & ~aft[3:0])) ? 1 : 0;
      c0 = int_cnt; wr_sel(din); clks(2); cs = din[5:4];
      checks++; if (reg_dout !== aft) begin errors++; $display("FAIL rnd_sel[%0d] got %h want %h", i, reg_dout, aft); end
      checks++; if (int_cnt - c0 != want) begin errors++; $display("FAIL rnd_sel_int[%0d] got %0d want %0d", i, int_cnt - c0, want); end
      nk = 10'($urandom);
`ifdef GB_JOYPAD_TURBO_EN
      nk[9:8] = 2'b00;
`endif
      bef = aft; aft = exp_dout(cs, nk, 4'b0);
      want = (|(bef[3:0] & ~aft[3:0])) ? 1 : 0;
      c0 = int_cnt; set_keys(nk); ticks(6); ck = nk;
      checks++; if (reg_dout !== aft) begin errors++; $display("FAIL rnd_key[%0d] got %h want %h", i, reg_dout, aft); end
      checks++; if (int_cnt - c0 != want) begin errors++; $display("FAIL rnd_key_int[%0d] got %0d want %0d", i, int_cnt - c0, want); end
    end
  endtask

  task automatic test_turbo();
    int n, lows;
    do_reset(); wr_sel(8'h10);
    key_square = 1;
`ifdef GB_JOYPAD_TURBO_EN
    n = 0;
    while (reg_dout[0] !== 1'b0 && n < 200) begin clks(1); n++; end
    checks++; if (reg_dout[0] !== 1'b0) begin errors++; $display("FAIL turbo_start got %b want 0", reg_dout[0]); end
    for (int p = 0; p < 3; p++) begin
      n = 0;
      while (reg_dout[0] === (p % 2 == 0 ? 1'b0 : 1'b1) && n < 2000) begin clks(1); n++; end
      checks++; if (n != TT * TD) begin errors++; $display("FAIL turbo_half[%0d] got %0d clks want %0d", p, n, TT * TD); end
    end
`else
    lows = 0;
    for (int t = 0; t < 80; t++) begin ticks(1); if (reg_dout[0] !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL turbo_off got %0d low samples want 0", lows); end
`endif
    key_square = 0;
  endtask

  task automatic test_mid_reset();
    do_reset(); wr_sel(8'h20); key_right = 1; ticks(6);
    rst_n = 1'b0; #1;
    checks++; if (reg_dout !== 8'hFF || int_req !== 1'b0) begin errors++; $display("FAIL mid_reset got %h/%b want ff/0", reg_dout, int_req); end
    key_right = 0; clks(2); rst_n = 1'b1; clks(2);
  endtask

  initial begin
    test_reset();
    test_sel_write();
    test_right();
    test_glitch();
    test_socd();
    test_stick();
    test_random();
    test_turbo();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
